pci_master_wbuf: RTL and testbench
==================================

# pci_master_wbuf

Write-side staging buffer that sits directly upstream of the PCI master controller. It accepts AXI4 write bursts (AW/W), stores the beats in a 1024-entry circular data buffer, and issues one write command per burst (`wcmd_*`). The controller fetches data by index through an asynchronous read port. Write responses (`wresp_*`) come back through a one-entry AXI B register, and each response releases that burst's buffer space.

## Interface
Parameters:
- `ADDR_W`, 10: buffer index width; the buffer depth is 2^ADDR_W = 1024. This value is fixed and must match the controller's 10-bit index.
- `ID_W`, 4: AXI ID width.

Ports:
- `clk` in 1: single clock. All logic is on the rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `s_awid` in ID_W: burst ID.
- `s_awaddr` in 64: burst byte address, passed through unmodified.
- `s_awlen` in 8: beats minus 1.
- `s_awvalid` in 1 / `s_awready` out 1: AW handshake.
- `s_wdata` in 32: write data beat.
- `s_wstrb` in 4: byte enables, active-high.
- `s_wlast` in 1: last-beat marker from the master.
- `s_wvalid` in 1 / `s_wready` out 1: W handshake.
- `s_bid` out ID_W: response ID.
- `s_bresp` out 2: response code.
- `s_bvalid` out 1 / `s_bready` in 1: B handshake.
- `wdata_idx` in 10: read index driven by the controller.
- `wdata_dout` out 32: buffer data at `wdata_idx`, combinational.
- `wdata_strb` out 4: buffer strobes at `wdata_idx`, combinational.
- `wcmd_id` out 4, `wcmd_len` out 8, `wcmd_addr` out 64: command fields; `wcmd_len` is beats minus 1.
- `wcmd_valid` out 1 / `wcmd_ready` in 1: command handshake.
- `wresp_id` in 4, `wresp_len` in 8, `wresp_err` in 2: response fields.
- `wresp_valid` in 1 / `wresp_ready` out 1: response handshake.
- `free_cnt` out 11: free buffer entries, range 0..1024.
- `err_wlast` out 1: sticky flag, set when `s_wlast` disagrees with the beat count.

## Operation
- Storage: 1024 × 36 bits (data plus strobe). Writes are synchronous on a W handshake, to address `wr_ptr`. Reads are asynchronous at `wdata_idx`.
- `wr_ptr` is a 10-bit counter that increments per accepted beat and wraps 1023→0. The controller's read index also starts at 0 after reset, so both sides must be reset together.
- State machine:
  - S_IDLE: `s_awready` = (`free_cnt` ≥ `s_awlen`+1). On AW handshake:
    - capture id/addr/len;
    - clear the beat counter;
    - reserve `s_awlen`+1 entries;
    - go to S_DATA.
  - S_DATA: `s_wready`=1. Each handshake writes one buffer entry and increments the beat counter. On the beat where count == len, go to S_CMD.
  - S_CMD: `wcmd_valid`=1, with fields held stable. On `wcmd_valid & wcmd_ready`, go to S_IDLE.
- The beat counter alone decides burst end; `s_wlast` does not.
  - `s_wlast`=1 on a non-final beat, or `s_wlast`=0 on the final beat, sets `err_wlast`.
  - `err_wlast` is cleared only by reset.
  - Data are stored regardless of `err_wlast`.
- Commands are issued in burst order. Data for a command is fully written before `wcmd_valid` rises, so the controller never reads an uncommitted entry.
- B register:
  - `wresp_ready` = !`s_bvalid`.
  - On a `wresp` handshake: `s_bid`←`wresp_id`, `s_bresp`←`wresp_err`, `s_bvalid`←1.
  - On `s_bvalid & s_bready`: `s_bvalid`←0.
- Free count:
  - `free_cnt` is decremented by `s_awlen`+1 on AW handshake.
  - It is incremented by `wresp_len`+1 on a `wresp` handshake.
  - Both in one cycle apply as a net update. The result must stay within 0..1024; exceeding 1024 is a design error, and the bench asserts on it.

## Timing
- Reset values:
  - state S_IDLE; `wr_ptr` 0; `free_cnt` 1024;
  - `s_awready` 0 during reset, then combinational;
  - `s_wready` 0; `s_bvalid` 0; `s_bid` 0; `s_bresp` 0;
  - `wcmd_valid` 0; `wcmd_id`/`len`/`addr` 0;
  - `wresp_ready` 1 after reset; `err_wlast` 0.
  - Buffer contents are not reset.
- AW handshake at cycle N → `s_wready`=1 at N+1.
- Final W beat at cycle M → `wcmd_valid`=1 at M+1. The written data are readable at M+1.
- `wcmd` handshake at cycle K → `wcmd_valid`=0 and `s_awready` eligible at K+1. The controller's `wcmd_ready` is a one-cycle pulse, and `wcmd_valid` must hold until that pulse.
- `wresp` handshake at cycle R → `s_bvalid`=1 and `free_cnt` updated at R+1.
- Reset mid-burst discards:
  - all captured state;
  - the partial data;
  - the pending command;
  - the pending B response.

## Test plan
1. AW id=3, addr 0x1000, len 0; W 0xDEADBEEF, strb 0xF, wlast=1:
   - `wcmd` (3, 0, 0x1000) is issued;
   - `wdata_idx`=0 returns 0xDEADBEEF/0xF;
   - `wresp` (3, 0, 0) → B id 3, OKAY;
   - `free_cnt` returns to 1024.
2. Five AW bursts of len 255, with no `wresp`:
   - the first four are accepted, leaving `free_cnt`=0;
   - the fifth stalls with `s_awready`=0;
   - one `wresp` with len 255 → fifth accepted one cycle later.
3. `wr_ptr` at 1020, 8-beat burst: data land at indices 1020–1023, then 0–3; the controller reads them back in order.
4. 4-beat burst with `s_wlast` on beat 2 → `err_wlast`=1; the command still has len 3 and all 4 beats are stored.
5. `s_bready`=0 with two back-to-back `wresp`:
   - the second sees `wresp_ready`=0 until the first B completes;
   - IDs come out in order; the `free_cnt` credits are exact.
6. Assert `rst_n`=0 mid-S_DATA after 5 of 16 beats:
   - all outputs take their reset values; `free_cnt`=1024;
   - the next 1-beat burst lands at index 0.

Source files
------------

// File: rtl/pci_master_wbuf.sv
// pci_master_wbuf: AXI4 write-burst staging buffer feeding the PCI master controller
// Ports: s_aw*/s_w*/s_b* AXI write slave; wdata_idx/wdata_dout/wdata_strb async buffer read;
// wcmd_* one command per burst; wresp_* completion credits; free_cnt free entries; err_wlast sticky.
module pci_master_wbuf #(
  parameter int ADDR_W = 10,
  parameter int ID_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ID_W-1:0]   s_awid,
  input  logic [63:0]       s_awaddr,
  input  logic [7:0]        s_awlen,
  input  logic              s_awvalid,
  output logic              s_awready,
  input  logic [31:0]       s_wdata,
  input  logic [3:0]        s_wstrb,
  input  logic              s_wlast,
  input  logic              s_wvalid,
  output logic              s_wready,
  output logic [ID_W-1:0]   s_bid,
  output logic [1:0]        s_bresp,
  output logic              s_bvalid,
  input  logic              s_bready,
  input  logic [ADDR_W-1:0] wdata_idx,
  output logic [31:0]       wdata_dout,
  output logic [3:0]        wdata_strb,
  output logic [ID_W-1:0]   wcmd_id,
  output logic [7:0]        wcmd_len,
  output logic [63:0]       wcmd_addr,
  output logic              wcmd_valid,
  input  logic              wcmd_ready,
  input  logic [ID_W-1:0]   wresp_id,
  input  logic [7:0]        wresp_len,
  input  logic [1:0]        wresp_err,
  input  logic              wresp_valid,
  output logic              wresp_ready,
  output logic [ADDR_W:0]   free_cnt,
  output logic              err_wlast
);
  typedef enum logic [1:0] {S_IDLE, S_DATA, S_CMD} state_t;
  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
  state_t            state, state_nx;
  logic [35:0]       mem [0:(1<<ADDR_W)-1];
  logic [ADDR_W-1:0] wr_ptr;
  logic [7:0]        beat_cnt;
  logic [ADDR_W:0]   aw_need, resp_cred, free_nx;
  logic              aw_hs, w_hs, resp_hs, final_beat;
  always_comb begin
    aw_need = (ADDR_W+1)'(s_awlen) + 1;
    resp_cred = (ADDR_W+1)'(wresp_len) + 1;
    s_awready = rst_n && state == S_IDLE && free_cnt >= aw_need;
    s_wready = state == S_DATA;
    wcmd_valid = state == S_CMD;
    wresp_ready = !s_bvalid;
    aw_hs = s_awvalid && s_awready;
    w_hs = s_wvalid && s_wready;
    resp_hs = wresp_valid && wresp_ready;
    // the beat counter, not s_wlast, ends the burst
    final_beat = beat_cnt == wcmd_len;
    free_nx = free_cnt - (aw_hs ? aw_need : '0) + (resp_hs ? resp_cred : '0);
    state_nx = aw_hs ? S_DATA :
               (w_hs && final_beat) ? S_CMD :
               (wcmd_valid && wcmd_ready) ? S_IDLE : state;
  end
  assign {wdata_strb, wdata_dout} = mem[wdata_idx];
  always_ff @(posedge clk)
    if (rst_n && w_hs) mem[wr_ptr] <= {s_wstrb, s_wdata};
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= S_IDLE;
      wr_ptr <= '0;
      beat_cnt <= '0;
      wcmd_id <= '0;
      wcmd_len <= '0;
      wcmd_addr <= '0;
      free_cnt <= DEPTH;
      s_bvalid <= 1'b0;
      s_bid <= '0;
      s_bresp <= '0;
      err_wlast <= 1'b0;
    end else begin
      state <= state_nx;
      free_cnt <= free_nx;
      if (aw_hs) begin
        wcmd_id <= s_awid;
        wcmd_addr <= s_awaddr;
        wcmd_len <= s_awlen;
        beat_cnt <= '0;
      end
      if (w_hs) begin
        wr_ptr <= wr_ptr + 1;
        beat_cnt <= beat_cnt + 1;
        err_wlast <= err_wlast | (s_wlast ^ final_beat);
      end
      if (resp_hs) begin
        s_bid <= wresp_id;
        s_bresp <= wresp_err;
        s_bvalid <= 1'b1;
      end else if (s_bvalid && s_bready) s_bvalid <= 1'b0;
    end
endmodule

// File: tb/tb_pci_master_wbuf.sv
// tb_pci_master_wbuf: directed plus random traffic against a queue/array reference model
module tb_pci_master_wbuf;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  logic [3:0] s_awid = 0, s_wstrb = 0, s_bid, wdata_strb, wcmd_id, wresp_id = 0;
  logic [63:0] s_awaddr = 0, wcmd_addr;
  logic [7:0] s_awlen = 0, wcmd_len, wresp_len = 0;
  logic s_awvalid = 0, s_awready, s_wlast = 0, s_wvalid = 0, s_wready, s_bvalid, s_bready = 1;
  logic [31:0] s_wdata = 0, wdata_dout;
  logic [1:0] s_bresp, wresp_err = 0;
  logic [9:0] wdata_idx = 0;
  logic wcmd_valid, wcmd_ready = 0, wresp_valid = 0, wresp_ready, err_wlast;
  logic [10:0] free_cnt;

  pci_master_wbuf dut (
    .clk(clk), .rst_n(rst_n), .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_wlast(s_wlast), .s_wvalid(s_wvalid), .s_wready(s_wready), .s_bid(s_bid),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready), .wdata_idx(wdata_idx),
    .wdata_dout(wdata_dout), .wdata_strb(wdata_strb), .wcmd_id(wcmd_id), .wcmd_len(wcmd_len),
    .wcmd_addr(wcmd_addr), .wcmd_valid(wcmd_valid), .wcmd_ready(wcmd_ready),
    .wresp_id(wresp_id), .wresp_len(wresp_len), .wresp_err(wresp_err),
    .wresp_valid(wresp_valid), .wresp_ready(wresp_ready), .free_cnt(free_cnt),
    .err_wlast(err_wlast));

  int passed = 0, total = 0;
  bit chk_en = 0;
  int m_left, m_ptr, m_free;
  bit m_cmd, m_bv, m_err, m_aw_took, m_w_took, m_c_took, m_r_took;
  logic [3:0] m_cid, m_bid;
  logic [1:0] m_bresp;
  logic [7:0] m_clen;
  logic [63:0] m_caddr;
  logic [35:0] m_mem [1024];
  bit m_wr [1024];
  logic e_aw, aw_hs, w_hs, c_hs, r_hs;
  assign e_aw = rst_n && m_left == 0 && !m_cmd && m_free >= int'(s_awlen) + 1;
  assign aw_hs = s_awvalid && e_aw;
  assign w_hs = s_wvalid && m_left > 0;
  assign c_hs = m_cmd && wcmd_ready;
  assign r_hs = wresp_valid && !m_bv;

  always @(posedge clk)
    if (!rst_n) begin
      m_left <= 0; m_ptr <= 0; m_free <= 1024; m_cmd <= 0; m_bv <= 0; m_err <= 0;
      m_bid <= 0; m_bresp <= 0; m_cid <= 0; m_clen <= 0; m_caddr <= 0;
      m_aw_took <= 0; m_w_took <= 0; m_c_took <= 0; m_r_took <= 0;
      for (int i = 0; i < 1024; i++) m_wr[i] <= 0;
    end else begin
      m_aw_took <= aw_hs; m_w_took <= w_hs; m_c_took <= c_hs; m_r_took <= r_hs;
      if (aw_hs) begin
        m_left <= int'(s_awlen) + 1; m_cid <= s_awid; m_clen <= s_awlen; m_caddr <= s_awaddr;
      end
      if (w_hs) begin
        m_mem[m_ptr] <= {s_wstrb, s_wdata};
        m_wr[m_ptr] <= 1;
        m_ptr <= (m_ptr + 1) % 1024;
        m_left <= m_left - 1;
        if (s_wlast != (m_left == 1)) m_err <= 1;
        if (m_left == 1) m_cmd <= 1;
      end
      if (c_hs) m_cmd <= 0;
      m_free <= m_free - (aw_hs ? int'(s_awlen) + 1 : 0) + (r_hs ? int'(wresp_len) + 1 : 0);
      if (r_hs) begin
        m_bv <= 1; m_bid <= wresp_id; m_bresp <= wresp_err;
      end else if (m_bv && s_bready) m_bv <= 0;
    end

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) $display("FAIL %s: got %h expected %h", n, a, e);
    else passed++;
  endtask

  always @(negedge clk)
    if (chk_en) begin
      chk("awready", 64'(s_awready), 64'(e_aw));
      chk("wready", 64'(s_wready), 64'(m_left > 0));
      chk("wcmd_valid", 64'(wcmd_valid), 64'(m_cmd));
      chk("wcmd_id", 64'(wcmd_id), 64'(m_cid));
      chk("wcmd_len", 64'(wcmd_len), 64'(m_clen));
      chk("wcmd_addr", wcmd_addr, m_caddr);
      chk("wresp_ready", 64'(wresp_ready), 64'(!m_bv));
      chk("bvalid", 64'(s_bvalid), 64'(m_bv));
      chk("bid", 64'(s_bid), 64'(m_bid));
      chk("bresp", 64'(s_bresp), 64'(m_bresp));
      chk("free_cnt", 64'(free_cnt), 64'(m_free));
      chk("free_range", 64'(free_cnt <= 11'd1024), 64'(1));
      chk("err_wlast", 64'(err_wlast), 64'(m_err));
      if (m_wr[wdata_idx]) chk("rd", 64'({wdata_strb, wdata_dout}), 64'(m_mem[wdata_idx]));
    end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wt(input int k, input string n);
    int t = 0;
    bit got;
    do begin
      tick();
      t++;
      got = k == 0 ? m_aw_took : k == 1 ? m_w_took : k == 2 ? m_c_took : m_r_took;
    end while (!got && t < 3000);
    if (!got) begin
      total++;
      $display("FAIL %s: handshake timeout after %0d cycles", n, t);
    end
  endtask

  task automatic aw(input logic [3:0] id, input logic [63:0] a, input logic [7:0] l);
    s_awid = id; s_awaddr = a; s_awlen = l; s_awvalid = 1;
    wt(0, "aw");
    s_awvalid = 0;
  endtask

  task automatic w(input logic [31:0] d, input logic [3:0] s, input logic l);
    s_wdata = d; s_wstrb = s; s_wlast = l; s_wvalid = 1;
    wt(1, "w");
    s_wvalid = 0;
  endtask

  task automatic cmd();
    wcmd_ready = 1;
    wt(2, "cmd");
    wcmd_ready = 0;
  endtask

  task automatic resp(input logic [3:0] id, input logic [7:0] l, input logic [1:0] e);
    wresp_id = id; wresp_len = l; wresp_err = e; wresp_valid = 1;
    wt(3, "resp");
    wresp_valid = 0;
  endtask

  task automatic burst(input logic [3:0] id, input logic [7:0] l, input bit rsp);
    aw(id, 64'h8000, l);
    for (int i = 0; i <= int'(l); i++) w($urandom, 4'hF, i == int'(l));
    cmd();
    if (rsp) resp(id, l, 0);
  endtask

  logic [11:0] rq [$];
  initial begin
    logic [9:0] ix;
    bit done;
    repeat (3) tick();
    rst_n = 1;
    chk_en = 1;
    chk("rst_free", 64'(free_cnt), 64'd1024);
    chk("rst_bvalid", 64'(s_bvalid), 64'd0);

    aw(3, 64'h1000, 0);
    w(32'hDEADBEEF, 4'hF, 1);
    chk("t1_valid", 64'(wcmd_valid), 64'd1);
    chk("t1_id", 64'(wcmd_id), 64'd3);
    chk("t1_len", 64'(wcmd_len), 64'd0);
    chk("t1_addr", wcmd_addr, 64'h1000);
    wdata_idx = 0;
    #1;
    chk("t1_data", 64'(wdata_dout), 64'hDEADBEEF);
    chk("t1_strb", 64'(wdata_strb), 64'hF);
    chk("t1_free", 64'(free_cnt), 64'd1023);
    cmd();
    resp(3, 0, 0);
    chk("t1_bvalid", 64'(s_bvalid), 64'd1);
    chk("t1_bid", 64'(s_bid), 64'd3);
    chk("t1_bresp", 64'(s_bresp), 64'd0);
    chk("t1_free2", 64'(free_cnt), 64'd1024);

    for (int i = 0; i < 4; i++) burst(4'(i), 8'd255, 0);
    chk("t2_free0", 64'(free_cnt), 64'd0);
    s_awid = 4; s_awaddr = 64'h9000; s_awlen = 255; s_awvalid = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t2_stall", 64'(s_awready), 64'd0);
    end
    resp(0, 255, 0);
    chk("t2_free256", 64'(free_cnt), 64'd256);
    chk("t2_awready", 64'(s_awready), 64'd1);
    tick();
    s_awvalid = 0;
    chk("t2_wready", 64'(s_wready), 64'd1);
    for (int i = 0; i < 256; i++) w($urandom, 4'hF, i == 255);
    cmd();
    for (int i = 1; i < 5; i++) resp(4'(i), 255, 0);
    chk("t2_free_end", 64'(free_cnt), 64'd1024);

    burst(1, 255, 1);
    burst(2, 255, 1);
    burst(3, 250, 1);
    aw(7, 64'h3000, 7);
    for (int i = 0; i < 8; i++) w(32'hA0 + 32'(i), 4'(i + 1), i == 7);
    for (int i = 0; i < 8; i++) begin
      ix = 10'd1020 + 10'(i);
      wdata_idx = ix;
      #1;
      chk("t3_data", 64'(wdata_dout), 64'hA0 + 64'(i));
      chk("t3_strb", 64'(wdata_strb), 64'(i + 1));
    end
    cmd();
    resp(7, 7, 0);

    aw(8, 64'h4000, 3);
    for (int i = 0; i < 4; i++) begin
      w(32'hC0 + 32'(i), 4'hF, i == 1);
      if (i == 1) chk("t4_err", 64'(err_wlast), 64'd1);
    end
    chk("t4_len", 64'(wcmd_len), 64'd3);
    for (int i = 0; i < 4; i++) begin
      wdata_idx = 10'(4 + i);
      #1;
      chk("t4_data", 64'(wdata_dout), 64'hC0 + 64'(i));
    end
    cmd();
    resp(8, 3, 0);

    burst(5, 0, 0);
    burst(6, 0, 0);
    s_bready = 0;
    resp(5, 0, 1);
    wresp_id = 6; wresp_len = 0; wresp_err = 2; wresp_valid = 1;
    for (int i = 0; i < 3; i++) begin
      chk("t5_wresp_ready", 64'(wresp_ready), 64'd0);
      chk("t5_bid1", 64'(s_bid), 64'd5);
      tick();
    end
    s_bready = 1;
    tick();
    s_bready = 0;
    chk("t5_ready_again", 64'(wresp_ready), 64'd1);
    wt(3, "t5_resp2");
    wresp_valid = 0;
    chk("t5_bid2", 64'(s_bid), 64'd6);
    chk("t5_bresp2", 64'(s_bresp), 64'd2);
    chk("t5_free", 64'(free_cnt), 64'd1024);
    s_bready = 1;
    tick();

    aw(9, 64'h5000, 15);
    for (int i = 0; i < 5; i++) w($urandom, 4'hF, 0);
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;
    chk("t6_free", 64'(free_cnt), 64'd1024);
    chk("t6_wready", 64'(s_wready), 64'd0);
    chk("t6_wcmd_valid", 64'(wcmd_valid), 64'd0);
    chk("t6_wcmd_addr", wcmd_addr, 64'd0);
    chk("t6_err", 64'(err_wlast), 64'd0);
    aw(1, 64'h2000, 0);
    w(32'h77, 4'hA, 1);
    wdata_idx = 0;
    #1;
    chk("t6_data", 64'(wdata_dout), 64'h77);
    chk("t6_strb", 64'(wdata_strb), 64'hA);
    cmd();
    resp(1, 0, 0);

    done = 0;
    for (int c = 0; c < 40000 && !done; c++) begin
      bit gen;
      gen = c < 4000;
      if (m_c_took) rq.push_back({m_cid, m_clen});
      if (s_awvalid && m_aw_took) s_awvalid = 0;
      if (gen && !s_awvalid && $urandom_range(3) == 0) begin
        s_awvalid = 1;
        s_awid = 4'($urandom);
        s_awaddr = {$urandom, $urandom};
        s_awlen = $urandom_range(7) == 0 ? 8'($urandom_range(255)) : 8'($urandom_range(15));
      end
      if (s_wvalid && m_w_took) s_wvalid = 0;
      if (!s_wvalid && m_left > 0 && $urandom_range(3) != 0) begin
        s_wvalid = 1;
        s_wdata = $urandom;
        s_wstrb = 4'($urandom);
        s_wlast = (m_left == 1) ^ ($urandom_range(63) == 0);
      end
      wcmd_ready = $urandom_range(2) == 0;
      if (wresp_valid && m_r_took) begin
        void'(rq.pop_front());
        wresp_valid = 0;
      end
      if (!wresp_valid && rq.size() > 0 && $urandom_range(2) == 0) begin
        wresp_valid = 1;
        {wresp_id, wresp_len} = rq[0];
        wresp_err = 2'($urandom_range(3));
      end
      s_bready = $urandom_range(3) != 0;
      wdata_idx = 10'(m_ptr - 1 - int'($urandom_range(7)));
      done = !gen && !s_awvalid && m_left == 0 && !m_cmd && rq.size() == 0 && !wresp_valid && !m_bv;
      if (!done) tick();
    end
    if (!done) begin
      total++;
      $display("FAIL drain: traffic did not settle");
    end
    chk("drain_free", 64'(free_cnt), 64'd1024);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
